floo_axis_vc_arbiter: RTL and testbench
=======================================

# floo_axis_vc_arbiter

Credit-based virtual-channel scheduler that multiplexes the FlooNoC request and response flit channels onto one shared AXI-Stream link of the NoC bridge. Each channel has its own send-credit counter, so a stalled channel never blocks the other. Credits freed by the local receiver are returned to the far side in the `tuser` field, piggybacked on data beats or sent in credit-only beats. The block sits between the chimney-side flit ports and the AXIS serial-link egress. A twin instance on the far end feeds this block's credit inputs.

## Interface
- `NumCredits`, default 8: receive-buffer depth per channel on the far side; also the initial send credits. Must be ≥1.
- `FlitDataSize`, default 64: flit payload width, handshake bits excluded.
- `CW`, derived: `$clog2(NumCredits+1)`, the credit field width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, **synchronous, active-low**.
- `req_valid_i` / `req_ready_o`  in/out  1  request flit handshake.
- `req_data_i`  in  FlitDataSize  request flit payload.
- `rsp_valid_i` / `rsp_ready_o`  in/out  1  response flit handshake.
- `rsp_data_i`  in  FlitDataSize  response flit payload.
- `free_req_i`, `free_rsp_i`  in  1  one pulse per local receive-buffer slot freed, per channel.
- `cred_in_valid_i`  in  1  incoming credit update from the far side is valid.
- `cred_in_hdr_i`  in  1  channel of the incoming update: 1 = req, 0 = rsp.
- `cred_in_cnt_i`  in  CW  number of credits returned by the far side.
- `axis_tvalid_o`  out  1  output beat valid.
- `axis_tready_i`  in  1  output beat accepted.
- `axis_tdata_o`  out  FlitDataSize+1  {hdr, payload}; hdr 1 = req, 0 = rsp.
- `axis_tuser_o`  out  CW+2  {data_valid, credit_hdr, credits}.
- `credits_req_o`, `credits_rsp_o`  out  CW  current send credits per channel.
- `error_o`  out  1  sticky credit-overflow flag.

## Operation
- **Send counters** `sc_req`, `sc_rsp`, each range 0..NumCredits.
  - A channel is eligible when its valid is high and its counter is > 0.
- **Output register:** a single stage.
  - `load = !axis_tvalid_o || axis_tready_i`.
  - On load, the register takes at most one flit plus one credit field.
- **Arbitration:** round-robin between the eligible channels.
  - `last` records the last granted channel; with both eligible, the channel other than `last` wins.
  - With one eligible, that channel wins.
  - `req_ready_o = load && grant==req`; `rsp_ready_o` likewise. Readies are combinational.
  - A channel with 0 credits gets ready = 0.
- **Flit transfer:** on input handshake, the granted channel's counter decrements and `last` updates.
  - The register loads `data_valid=1` and the hdr of the granted channel.
- **Pending return counters** `pr_req`, `pr_rsp`, range 0..NumCredits.
  - Each increments on its `free_*_i` pulse.
- **Piggyback selection:** every loaded beat carries the channel with the larger pending count; a tie selects req.
  - `credits` = that channel's full pending count; `credit_hdr` = that channel.
  - On load, that pending counter becomes `0 + free pulse of the same cycle`.
- **Credit-only beat:** when no channel is eligible, load is high and either pending counter is > 0.
  - The beat loads `data_valid=0`, payload all zero, credit fields as above.
- **Nothing to send:** no eligible channel and both pending counters 0 → no load; `axis_tvalid_o` drops after the handshake.
- **Incoming credits:** on `cred_in_valid_i`, add `cred_in_cnt_i` to the selected send counter.
  - If the sum exceeds NumCredits: saturate at NumCredits and set `error_o`.
  - `error_o` clears only on reset.
- **Same-cycle events:** consumption and incoming credit on the same counter in one cycle are applied as the net `sc + cnt - 1`.
- **Stability:** while `axis_tvalid_o && !axis_tready_i`, all output fields hold stable.

## Timing
- **Reset** (`rst_ni` low at a clock edge):
  - `axis_tvalid_o=0`, `axis_tdata_o=0`, `axis_tuser_o=0`, `error_o=0`.
  - Send counters = NumCredits, pending counters = 0, `last` = rsp, so req wins first.
  - Readies follow the combinational rule, and are therefore high right after reset when valid is high.
  - Reset mid-transfer discards the registered beat.
- **Latency:** input handshake in cycle N → `axis_tvalid_o` high in cycle N+1.
- **Throughput:** one beat per cycle while `axis_tready_i` stays high.
- **Credit visibility:**
  - A `free_*_i` pulse appears at the earliest in the beat loaded in the following cycle.
  - An incoming credit is usable for a grant in the cycle after `cred_in_valid_i`.

## Test plan
- **Basic multiplexing:** NumCredits=8, both channels valid continuously, tready=1, far side never returns credits → output alternates req, rsp, req, …; exactly 8 beats of each; then both readies stay 0 and `axis_tvalid_o` falls.
- **Channel independence:** req is exhausted (`sc_req=0`) and rsp is valid → rsp beats continue every cycle, `req_ready_o=0`; one `cred_in` (hdr=1, cnt=3) → exactly 3 more req grants.
- **Backpressure:** tready=0 for 5 cycles with a beat loaded → tdata and tuser unchanged, both readies 0; tready=1 → next beat on the following cycle.
- **Credit return:** 3 `free_rsp_i` pulses, no flits valid → one credit-only beat with tuser={0,0,3}; then `pr_rsp=0` and no further beats. With `pr_req=2` and `pr_rsp=2`, the next beat carries hdr=req, credits 2.
- **Overflow:** `sc_req=8` and `cred_in` cnt=1 → `sc_req` stays 8 and `error_o=1` until reset.
- **Reset mid-stream:** assert `rst_ni=0` for one cycle while tvalid=1 → next cycle tvalid=0, credits 8/8, `error_o=0`.

Source files
------------

// File: rtl/floo_axis_vc_arbiter.sv
// Credit-based two-channel (req/rsp) scheduler onto one AXI-Stream beat register.
// Each beat also piggybacks returned credits for the channel with the most pending frees.
module floo_axis_vc_arbiter #(
  parameter int unsigned NumCredits   = 8,
  parameter int unsigned FlitDataSize = 64,
  localparam int unsigned CW          = $clog2(NumCredits + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [FlitDataSize-1:0] req_data_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  input  logic [FlitDataSize-1:0] rsp_data_i,
  input  logic                    free_req_i,
  input  logic                    free_rsp_i,
  input  logic                    cred_in_valid_i,
  input  logic                    cred_in_hdr_i,
  input  logic [CW-1:0]           cred_in_cnt_i,
  output logic                    axis_tvalid_o,
  input  logic                    axis_tready_i,
  output logic [FlitDataSize:0]   axis_tdata_o,
  output logic [CW+1:0]           axis_tuser_o,
  output logic [CW-1:0]           credits_req_o,
  output logic [CW-1:0]           credits_rsp_o,
  output logic                    error_o
);

  localparam int unsigned CWE = CW + 1;
  localparam int unsigned TDW = FlitDataSize + 1;
  localparam int unsigned TUW = CW + 2;
  localparam logic [CWE-1:0] MaxCredWide = CWE'(NumCredits);
  localparam logic [CW-1:0]  MaxCred     = CW'(NumCredits);

  logic [CW-1:0]  r_sc_req;
  logic [CW-1:0]  r_sc_rsp;
  logic [CW-1:0]  r_pr_req;
  logic [CW-1:0]  r_pr_rsp;
  logic           r_last_req;
  logic           r_tvalid;
  logic [TDW-1:0] r_tdata;
  logic [TUW-1:0] r_tuser;
  logic           r_error;

  logic           w_load;
  logic           w_elig_req;
  logic           w_elig_rsp;
  logic           w_gnt_req;
  logic           w_gnt_rsp;
  logic           w_take_req;
  logic           w_take_rsp;
  logic           w_pb_req;
  logic [CW-1:0]  w_pb_cnt;
  logic           w_pend_any;
  logic           w_beat;
  logic           w_cred_req;
  logic           w_cred_rsp;
  logic [CWE-1:0] w_sc_req_sum;
  logic [CWE-1:0] w_sc_rsp_sum;
  logic           w_ovf_req;
  logic           w_ovf_rsp;
  logic [CW-1:0]  w_sc_req_nxt;
  logic [CW-1:0]  w_sc_rsp_nxt;
  logic [CW-1:0]  w_pr_req_nxt;
  logic [CW-1:0]  w_pr_rsp_nxt;
  logic [TDW-1:0] w_tdata_nxt;
  logic [TUW-1:0] w_tuser_nxt;

  // Round-robin grant; with both eligible the channel not served last wins.
  always_comb begin
    w_load     = !r_tvalid || axis_tready_i;
    w_elig_req = req_valid_i && (r_sc_req != '0);
    w_elig_rsp = rsp_valid_i && (r_sc_rsp != '0);
    w_gnt_req  = w_elig_req && (!w_elig_rsp || !r_last_req);
    w_gnt_rsp  = w_elig_rsp && !w_gnt_req;
    w_take_req = w_load && w_gnt_req;
    w_take_rsp = w_load && w_gnt_rsp;
  end

  assign req_ready_o = w_take_req;
  assign rsp_ready_o = w_take_rsp;

  // Piggyback the larger pending return count; ties favour req.
  always_comb begin
    w_pb_req   = (r_pr_req >= r_pr_rsp);
    w_pb_cnt   = w_pb_req ? r_pr_req : r_pr_rsp;
    w_pend_any = (r_pr_req != '0) || (r_pr_rsp != '0);
    w_beat     = w_load && (w_gnt_req || w_gnt_rsp || w_pend_any);
  end

  always_comb begin
    w_pr_req_nxt = r_pr_req;
    w_pr_rsp_nxt = r_pr_rsp;
    if (w_beat && w_pb_req) begin
      w_pr_req_nxt = CW'(free_req_i);
    end else if (free_req_i && (r_pr_req != MaxCred)) begin
      w_pr_req_nxt = r_pr_req + CW'(1);
    end
    if (w_beat && !w_pb_req) begin
      w_pr_rsp_nxt = CW'(free_rsp_i);
    end else if (free_rsp_i && (r_pr_rsp != MaxCred)) begin
      w_pr_rsp_nxt = r_pr_rsp + CW'(1);
    end
  end

  // Net send-credit update: incoming credits minus same-cycle consumption, saturating.
  always_comb begin
    w_cred_req   = cred_in_valid_i && cred_in_hdr_i;
    w_cred_rsp   = cred_in_valid_i && !cred_in_hdr_i;
    w_sc_req_sum = CWE'(r_sc_req) + (w_cred_req ? CWE'(cred_in_cnt_i) : CWE'(0))
                 - CWE'(w_take_req);
    w_sc_rsp_sum = CWE'(r_sc_rsp) + (w_cred_rsp ? CWE'(cred_in_cnt_i) : CWE'(0))
                 - CWE'(w_take_rsp);
    w_ovf_req    = (w_sc_req_sum > MaxCredWide);
    w_ovf_rsp    = (w_sc_rsp_sum > MaxCredWide);
    w_sc_req_nxt = w_ovf_req ? MaxCred : w_sc_req_sum[CW-1:0];
    w_sc_rsp_nxt = w_ovf_rsp ? MaxCred : w_sc_rsp_sum[CW-1:0];
  end

  always_comb begin
    w_tdata_nxt = '0;
    if (w_gnt_req) begin
      w_tdata_nxt = {1'b1, req_data_i};
    end else if (w_gnt_rsp) begin
      w_tdata_nxt = {1'b0, rsp_data_i};
    end
    w_tuser_nxt = {(w_gnt_req || w_gnt_rsp), w_pb_req, w_pb_cnt};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sc_req   <= MaxCred;
      r_sc_rsp   <= MaxCred;
      r_pr_req   <= '0;
      r_pr_rsp   <= '0;
      r_last_req <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_sc_req <= w_sc_req_nxt;
      r_sc_rsp <= w_sc_rsp_nxt;
      r_pr_req <= w_pr_req_nxt;
      r_pr_rsp <= w_pr_rsp_nxt;
      r_error  <= r_error || w_ovf_req || w_ovf_rsp;
      if (w_take_req) begin
        r_last_req <= 1'b1;
      end else if (w_take_rsp) begin
        r_last_req <= 1'b0;
      end
    end
  end

  // Output stage: fields only change when the register may load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
    end else if (w_beat) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_tdata_nxt;
      r_tuser  <= w_tuser_nxt;
    end else if (w_load) begin
      r_tvalid <= 1'b0;
    end
  end

  assign axis_tvalid_o = r_tvalid;
  assign axis_tdata_o  = r_tdata;
  assign axis_tuser_o  = r_tuser;
  assign credits_req_o = r_sc_req;
  assign credits_rsp_o = r_sc_rsp;
  assign error_o       = r_error;

endmodule

// File: tb/tb_floo_axis_vc_arbiter.sv
// Randomized + directed bench for floo_axis_vc_arbiter against a cycle-level reference model.
module tb_floo_axis_vc_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned FD = 64;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, rsp_valid;
  logic [FD-1:0] req_data, rsp_data;
  logic          free_req, free_rsp;
  logic          cred_valid, cred_hdr;
  logic [CW-1:0] cred_cnt;
  logic          tready;

  logic          req_ready_o, rsp_ready_o;
  logic          axis_tvalid_o;
  logic [FD:0]   axis_tdata_o;
  logic [CW+1:0] axis_tuser_o;
  logic [CW-1:0] credits_req_o, credits_rsp_o;
  logic          error_o;

  floo_axis_vc_arbiter #(.NumCredits(N), .FlitDataSize(FD)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_data_i     (req_data),
    .rsp_valid_i    (rsp_valid),
    .rsp_ready_o    (rsp_ready_o),
    .rsp_data_i     (rsp_data),
    .free_req_i     (free_req),
    .free_rsp_i     (free_rsp),
    .cred_in_valid_i(cred_valid),
    .cred_in_hdr_i  (cred_hdr),
    .cred_in_cnt_i  (cred_cnt),
    .axis_tvalid_o  (axis_tvalid_o),
    .axis_tready_i  (tready),
    .axis_tdata_o   (axis_tdata_o),
    .axis_tuser_o   (axis_tuser_o),
    .credits_req_o  (credits_req_o),
    .credits_rsp_o  (credits_rsp_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_req_gnt, n_rsp_gnt;

  // Reference model: index 1 = req channel, 0 = rsp channel.
  int          m_sc[2];
  int          m_pr[2];
  int          m_last;
  bit          m_err;
  bit          m_tv;
  logic [FD:0] m_tdata;
  logic [CW+1:0] m_tuser;
  bit          m_known = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check combinational readies, advance model, check registered outputs.
  task automatic step();
    bit load;
    bit e[2];
    bit fr[2];
    int g, pb, pc, inc;
    bit beat;
    int nsc[2], npr[2];
    #1;
    load = !m_tv || tready;
    e[1] = req_valid && (m_sc[1] > 0);
    e[0] = rsp_valid && (m_sc[0] > 0);
    if (e[1] && e[0]) g = 1 - m_last;
    else if (e[1])    g = 1;
    else if (e[0])    g = 0;
    else              g = -1;
    if (m_known) begin
      check("req_ready", 128'(req_ready_o), 128'(load && g == 1));
      check("rsp_ready", 128'(rsp_ready_o), 128'(load && g == 0));
    end
    if (rst_n && req_ready_o && req_valid) n_req_gnt++;
    if (rst_n && rsp_ready_o && rsp_valid) n_rsp_gnt++;

    if (!rst_n) begin
      m_sc = '{N, N};
      m_pr = '{0, 0};
      m_last = 0; m_err = 0; m_tv = 0; m_tdata = '0; m_tuser = '0; m_known = 1;
    end else begin
      fr[1] = free_req; fr[0] = free_rsp;
      pb = (m_pr[1] >= m_pr[0]) ? 1 : 0;
      pc = m_pr[pb];
      beat = load && (g >= 0 || m_pr[0] > 0 || m_pr[1] > 0);
      for (int c = 0; c < 2; c++) begin
        if (beat && c == pb) npr[c] = int'(fr[c]);
        else npr[c] = (m_pr[c] + int'(fr[c]) > N) ? N : m_pr[c] + int'(fr[c]);
        inc = (cred_valid && (int'(cred_hdr) == c)) ? int'(cred_cnt) : 0;
        nsc[c] = m_sc[c] + inc - ((load && g == c) ? 1 : 0);
        if (nsc[c] > N) begin
          nsc[c] = N;
          m_err = 1;
        end
      end
      if (load && g >= 0) m_last = g;
      if (beat) begin
        m_tv = 1;
        if (g == 1)      m_tdata = {1'b1, req_data};
        else if (g == 0) m_tdata = {1'b0, rsp_data};
        else             m_tdata = '0;
        m_tuser = {(g >= 0), 1'(pb), CW'(pc)};
      end else if (load) begin
        m_tv = 0;
      end
      m_sc = nsc;
      m_pr = npr;
    end

    @(posedge clk);
    #1;
    check("tvalid", 128'(axis_tvalid_o), 128'(m_tv));
    check("tdata", 128'(axis_tdata_o), 128'(m_tdata));
    check("tuser", 128'(axis_tuser_o), 128'(m_tuser));
    check("credits_req", 128'(credits_req_o), 128'(m_sc[1]));
    check("credits_rsp", 128'(credits_rsp_o), 128'(m_sc[0]));
    check("error", 128'(error_o), 128'(m_err));
  endtask

  task automatic idle_inputs();
    req_valid = 0; rsp_valid = 0; free_req = 0; free_rsp = 0;
    cred_valid = 0; cred_hdr = 0; cred_cnt = '0;
    req_data = {$urandom, $urandom}; rsp_data = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic rand_inputs(input int pv, input int pt, input int pf, input int pcred, input bit wild);
    int c;
    req_valid = ($urandom_range(0, 99) < pv);
    rsp_valid = ($urandom_range(0, 99) < pv);
    req_data  = {$urandom, $urandom};
    rsp_data  = {$urandom, $urandom};
    tready    = ($urandom_range(0, 99) < pt);
    free_req  = ($urandom_range(0, 99) < pf);
    free_rsp  = ($urandom_range(0, 99) < pf);
    cred_valid = ($urandom_range(0, 99) < pcred);
    cred_hdr  = 1'($urandom_range(0, 1));
    c = int'(cred_hdr);
    if (wild && $urandom_range(0, 99) < 3) cred_cnt = CW'($urandom_range(0, 15));
    else cred_cnt = CW'($urandom_range(0, N - m_sc[c]));
  endtask

  initial begin
    logic [CW+1:0] exp_tuser;
    idle_inputs();
    tready = 1;
    rst_n = 0;
    step();
    do_reset();
    check("rst_tvalid", 128'(axis_tvalid_o), 128'(0));
    check("rst_cred_req", 128'(credits_req_o), 128'(N));
    check("rst_cred_rsp", 128'(credits_rsp_o), 128'(N));
    check("rst_error", 128'(error_o), 128'(0));

    // Basic multiplexing, no credits returned.
    req_valid = 1; rsp_valid = 1; tready = 1;
    n_req_gnt = 0; n_rsp_gnt = 0;
    repeat (24) begin
      req_data = {$urandom, $urandom}; rsp_data = {$urandom, $urandom};
      step();
    end
    check("mux_req_gnts", 128'(n_req_gnt), 128'(N));
    check("mux_rsp_gnts", 128'(n_rsp_gnt), 128'(N));
    check("mux_tvalid_low", 128'(axis_tvalid_o), 128'(0));
    check("mux_req_ready_low", 128'(req_ready_o), 128'(0));

    // Channel independence.
    cred_valid = 1; cred_hdr = 0; cred_cnt = CW'(N);
    step();
    cred_valid = 0;
    n_req_gnt = 0; n_rsp_gnt = 0;
    repeat (4) step();
    check("indep_req_gnts", 128'(n_req_gnt), 128'(0));
    check("indep_rsp_gnts", 128'(n_rsp_gnt), 128'(4));
    n_req_gnt = 0;
    cred_valid = 1; cred_hdr = 1; cred_cnt = CW'(3);
    step();
    cred_valid = 0;
    repeat (12) step();
    check("indep_req_after_cred", 128'(n_req_gnt), 128'(3));

    // Backpressure.
    idle_inputs();
    do_reset();
    req_valid = 1; tready = 1;
    step();
    tready = 0;
    repeat (5) begin
      req_data = {$urandom, $urandom};
      step();
      check("bp_req_ready", 128'(req_ready_o), 128'(0));
    end
    tready = 1;
    step();
    check("bp_resume_tvalid", 128'(axis_tvalid_o), 128'(1));

    // Credit return: credit-only beats.
    idle_inputs();
    do_reset();
    req_valid = 1; tready = 0;
    step();
    req_valid = 0; free_rsp = 1;
    repeat (3) step();
    free_rsp = 0; tready = 1;
    step();
    exp_tuser = {1'b0, 1'b0, CW'(3)};
    check("cret_tuser_rsp3", 128'(axis_tuser_o), 128'(exp_tuser));
    check("cret_tdata_zero", 128'(axis_tdata_o), 128'(0));
    step();
    check("cret_idle", 128'(axis_tvalid_o), 128'(0));
    req_valid = 1; tready = 0;
    step();
    req_valid = 0; free_req = 1; free_rsp = 1;
    repeat (2) step();
    free_req = 0; free_rsp = 0; tready = 1;
    step();
    exp_tuser = {1'b0, 1'b1, CW'(2)};
    check("cret_tie_req", 128'(axis_tuser_o), 128'(exp_tuser));

    // Overflow.
    idle_inputs();
    do_reset();
    cred_valid = 1; cred_hdr = 1; cred_cnt = CW'(1);
    step();
    cred_valid = 0;
    check("ovf_error", 128'(error_o), 128'(1));
    check("ovf_sat", 128'(credits_req_o), 128'(N));
    repeat (3) step();
    check("ovf_sticky", 128'(error_o), 128'(1));

    // Reset mid-stream.
    req_valid = 1; rsp_valid = 1; tready = 0;
    step();
    check("mid_tvalid_before", 128'(axis_tvalid_o), 128'(1));
    do_reset();
    check("mid_tvalid", 128'(axis_tvalid_o), 128'(0));
    check("mid_cred_req", 128'(credits_req_o), 128'(N));
    check("mid_cred_rsp", 128'(credits_rsp_o), 128'(N));
    check("mid_error", 128'(error_o), 128'(0));

    // Random phases.
    repeat (400) begin rand_inputs(80, 90, 20, 25, 0); step(); end
    repeat (400) begin rand_inputs(50, 40, 40, 15, 0); step(); end
    repeat (400) begin
      rand_inputs(60, 70, 30, 30, 1);
      if ($urandom_range(0, 99) == 0) rst_n = 0;
      step();
      rst_n = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
